// File: rtl/rr_index_arbiter_pkg.sv
// Shared constants and state encoding for the four-requester round-robin arbiter.
// The downstream 2-to-4 decoder uses the same IDX_W.
package rr_index_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin pick.
// The request vector is rotated right by ptr, a fixed-priority pick is taken
// (lowest bit wins), and ptr is added back modulo 4.
module rr_pick
    import rr_index_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   pick;

    // Rotate, fixed-priority pick, then rotate the chosen index back.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rot  = '0;
        pick = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pick = IDX_W'(i);
        end
        any    = |rot;
        winner = pick + ptr;
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// Four-requester round-robin arbiter with registered binary grant index.
// A grant is held until done, loss of the owner's request, or the hold limit.
// Every release is followed by at least one IDLE cycle.
module rr_index_arbiter
    import rr_index_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_index,
    output logic               timeout
);

    localparam bit               TO_EN     = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_index_q, grant_index_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] winner;
    logic             any;
    logic             rel_done, rel_drop, rel_to;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    // Release causes, only meaningful while in GRANT.
    always_comb begin
        rel_done = done;
        rel_drop = ~req[grant_index_q];
        rel_to   = TO_EN && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state logic: arbitration in IDLE, hold/release in GRANT.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        timeout_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d       = ST_GRANT;
                    grant_index_d = winner;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_to) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_index_q + IDX_W'(1);
                    hold_cnt_d    = '0;
                    // Forced release is flagged only when nothing else caused it.
                    timeout_d     = rel_to && !rel_done && !rel_drop;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed self-checking bench for rr_index_arbiter.
// dut0 uses HOLD_MAX=16; dut1 uses HOLD_MAX=0 (timeout disabled).
module tb_rr_index_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_index;
    logic       timeout;

    logic [3:0] req1 = '0;
    logic       done1 = 1'b0;
    logic       grant_valid1;
    logic [1:0] grant_index1;
    logic       timeout1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_index_arbiter #(.HOLD_MAX(16), .CNT_W(8)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .timeout     (timeout)
    );

    rr_index_arbiter #(.HOLD_MAX(0), .CNT_W(8)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req1),
        .done        (done1),
        .grant_valid (grant_valid1),
        .grant_index (grant_index1),
        .timeout     (timeout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        req1  = '0;
        done1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};
    bit bad_valid;
    bit bad_to;

    initial begin
        // 1: reset state, idle with no requests, asynchronous reset mid-grant
        do_reset();
        check("rst_valid", grant_valid, 0);
        check("rst_index", grant_index, 0);
        check("rst_timeout", timeout, 0);
        bad_valid = 0;
        bad_to    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant_valid !== 1'b0 || grant_index !== 2'd0) bad_valid = 1;
            if (timeout !== 1'b0) bad_to = 1;
        end
        check("idle_no_req_outputs", bad_valid, 0);
        check("idle_no_req_timeout", bad_to, 0);
        req = 4'b0001;
        tick();
        check("pre_async_valid", grant_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", grant_valid, 0);
        check("async_rst_index", grant_index, 0);

        // 2: single requester 2, hold limit 16 cycles then timeout
        do_reset();
        req = 4'b0100;
        tick();
        check("t2_grant_valid", grant_valid, 1);
        check("t2_grant_index", grant_index, 2);
        bad_valid = 0;
        bad_to    = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (grant_valid !== 1'b1 || grant_index !== 2'd2) bad_valid = 1;
            if (timeout !== 1'b0) bad_to = 1;
        end
        check("t2_held_16", bad_valid, 0);
        check("t2_no_early_timeout", bad_to, 0);
        tick();
        check("t2_release_valid", grant_valid, 0);
        check("t2_timeout_pulse", timeout, 1);
        check("t2_index_kept", grant_index, 2);
        tick();
        check("t2_regrant_valid", grant_valid, 1);
        check("t2_regrant_index", grant_index, 2);
        check("t2_timeout_one_cycle", timeout, 0);
        req = 4'b0000;
        tick();
        check("t2_drop_release", grant_valid, 0);
        check("t2_drop_no_timeout", timeout, 0);

        // 3: all requesting, owner pulses done after 3 cycles
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check($sformatf("t3_g%0d_valid", g), grant_valid, 1);
            check($sformatf("t3_g%0d_index", g), grant_index, exp_seq[g]);
            tick();
            check($sformatf("t3_g%0d_hold1", g), grant_valid, 1);
            tick();
            check($sformatf("t3_g%0d_hold2", g), grant_valid, 1);
            done = 1'b1;
            tick();
            done = 1'b0;
            check($sformatf("t3_g%0d_gap", g), grant_valid, 0);
            check($sformatf("t3_g%0d_timeout", g), timeout, 0);
        end
        req = 4'b0000;

        // 4: owner 3 drops its request, next grant wraps to 0
        do_reset();
        req = 4'b1000;
        tick();
        check("t4_grant3_index", grant_index, 3);
        check("t4_grant3_valid", grant_valid, 1);
        req = 4'b1001;
        tick();
        check("t4_other_req_ignored", grant_index, 3);
        check("t4_still_valid", grant_valid, 1);
        req = 4'b0001;
        tick();
        check("t4_drop_release", grant_valid, 0);
        check("t4_drop_no_timeout", timeout, 0);
        tick();
        check("t4_wrap_valid", grant_valid, 1);
        check("t4_wrap_index", grant_index, 0);
        req = 4'b0000;
        tick();

        // 5: done coincides with the hold limit; done in IDLE is ignored
        do_reset();
        req = 4'b0001;
        tick();
        check("t5_grant_index", grant_index, 0);
        repeat (15) tick();
        check("t5_before_limit", grant_valid, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        check("t5_release_valid", grant_valid, 0);
        check("t5_coincide_no_timeout", timeout, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_idle_done_valid", grant_valid, 0);
        check("t5_idle_done_index", grant_index, 0);
        check("t5_idle_done_timeout", timeout, 0);
        req = 4'b0011;
        tick();
        check("t5_next_prio_index", grant_index, 1);
        check("t5_next_prio_valid", grant_valid, 1);
        req = 4'b0000;
        tick();

        // 6: HOLD_MAX=0 never times out; hold counter saturates
        do_reset();
        req1 = 4'b0010;
        tick();
        check("t6_grant_valid", grant_valid1, 1);
        check("t6_grant_index", grant_index1, 1);
        bad_valid = 0;
        bad_to    = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant_valid1 !== 1'b1 || grant_index1 !== 2'd1) bad_valid = 1;
            if (timeout1 !== 1'b0) bad_to = 1;
        end
        check("t6_never_released", bad_valid, 0);
        check("t6_never_timeout", bad_to, 0);
        check("t6_hold_cnt_sat", dut1.hold_cnt_q, 255);
        req1 = 4'b0000;
        tick();
        check("t6_drop_release", grant_valid1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
